// File: rtl/aes_round_ctrl_if.sv
// Handshake bundle between the AES round controller, its key schedule and round datapath.
// The slave modport is the controller's view; master is the environment's view.
interface aes_round_ctrl_if;
  logic         start;
  logic [127:0] din;
  logic         abort;
  logic         ready;
  logic         busy;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk;
  logic [127:0] dp_state;
  logic [3:0]   dp_round;
  logic         dp_final;
  logic [127:0] dp_result;
  logic [127:0] dout;
  logic         done;

  modport master (
    output start, din, abort, rk_valid, rk, dp_result,
    input  ready, busy, rk_req, rk_idx, dp_state, dp_round, dp_final, dout, done
  );

  modport slave (
    input  start, din, abort, rk_valid, rk, dp_result,
    output ready, busy, rk_req, rk_idx, dp_state, dp_round, dp_final, dout, done
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: walks the initial key add plus NR rounds, fetching one
// round key per step and feeding the external round datapath, then publishes the ciphertext.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input logic              clk,
  input logic              rst_n,
  aes_round_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StKey0, StRnd, StDone} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;

  logic last_round;
  assign last_round = (round_q == 4'(NR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      round_q <= 4'd0;
      state_q <= 128'd0;
      dout_q  <= 128'd0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    dout_d  = dout_q;
    unique case (fsm_q)
      StIdle: begin
        if (bus.start) begin
          state_d = bus.din;
          round_d = 4'd0;
          fsm_d   = StKey0;
        end
      end
      StKey0: begin
        // Abort wins over a key arriving in the same cycle.
        if (bus.abort) begin
          round_d = 4'd0;
          fsm_d   = StIdle;
        end else if (bus.rk_valid) begin
          state_d = state_q ^ bus.rk;
          round_d = 4'd1;
          fsm_d   = StRnd;
        end
      end
      StRnd: begin
        if (bus.abort) begin
          round_d = 4'd0;
          fsm_d   = StIdle;
        end else if (bus.rk_valid) begin
          state_d = bus.dp_result;
          if (last_round) begin
            dout_d  = bus.dp_result;
            round_d = 4'd0;
            fsm_d   = StDone;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      StDone: begin
        fsm_d = StIdle;
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.ready    = 1'b0;
    bus.rk_req   = 1'b0;
    bus.rk_idx   = 4'd0;
    bus.dp_round = 4'd0;
    bus.dp_final = 1'b0;
    bus.done     = 1'b0;
    unique case (fsm_q)
      StIdle: bus.ready = 1'b1;
      StKey0: bus.rk_req = 1'b1;
      StRnd: begin
        bus.rk_req   = 1'b1;
        bus.rk_idx   = round_q;
        bus.dp_round = round_q;
        bus.dp_final = last_round;
      end
      StDone: bus.done = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  assign bus.busy     = ~bus.ready;
  assign bus.dp_state = state_q;
  assign bus.dout     = dout_q;

endmodule
